// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vram_pkg
//  Description : Shared geometry constants and the grant encoding for the
//                VRAM arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PIX_W    = 12;
    localparam int ADDR_W   = 19;
    localparam int ROW_W    = 9;
    localparam int COL_W    = 10;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_W0   = 2'd2,
        GNT_W1   = 2'd3
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/vram_addr_calc.sv
`default_nettype none
// ============================================================================
//  Module      : vram_addr_calc
//  Description : Combinational (row, col) to linear VRAM address,
//                addr = row*H_ACTIVE + col, zero-extended, no saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_addr_calc
    import vram_pkg::*;
(
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] w_row_ext;
    logic [ADDR_W-1:0] w_col_ext;

    assign w_row_ext = ADDR_W'(row);
    assign w_col_ext = ADDR_W'(col);

    generate
        if (H_ACTIVE == 640) begin : g_shift_add
            // 640 = 512 + 128, so two shifts and an add replace the multiplier
            assign addr = (w_row_ext << 9) + (w_row_ext << 7) + w_col_ext;
        end else begin : g_mult
            assign addr = (w_row_ext * ADDR_W'(H_ACTIVE)) + w_col_ext;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arbiter
//  Description : Shares one single-port VRAM between the display fetch
//                (absolute priority, fixed 3-cycle read latency) and two
//                round-robin pixel writers. Optional macro VRAM_WR_CLIP_EN
//                drops out-of-range writes and counts them on clip_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,

    input  logic              disp_req,
    input  logic [ROW_W-1:0]  disp_row,
    input  logic [COL_W-1:0]  disp_col,
    output logic [PIX_W-1:0]  disp_data,
    output logic              disp_valid,

    input  logic              w0_valid,
    output logic              w0_ready,
    input  logic [ROW_W-1:0]  w0_row,
    input  logic [COL_W-1:0]  w0_col,
    input  logic [PIX_W-1:0]  w0_data,

    input  logic              w1_valid,
    output logic              w1_ready,
    input  logic [ROW_W-1:0]  w1_row,
    input  logic [COL_W-1:0]  w1_col,
    input  logic [PIX_W-1:0]  w1_data,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_din,
    input  logic [PIX_W-1:0]  mem_dout
`ifdef VRAM_WR_CLIP_EN
    ,
    output logic [15:0]       clip_cnt
`endif
);

    grant_t            w_grant;
    logic [ROW_W-1:0]  w_sel_row;
    logic [COL_W-1:0]  w_sel_col;
    logic [PIX_W-1:0]  w_sel_data;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_is_write;
    logic              w_clip;
    logic              w_issue;

    logic              r_rr_ptr;      // 0: writer 0 wins the next contention
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [PIX_W-1:0]  r_mem_din;
    logic              r_rd_s1;
    logic              r_rd_s2;
    logic              r_disp_valid;
    logic [PIX_W-1:0]  r_disp_data;

    // No grant while in reset: a handshake taken then would be silently lost.
    always_comb begin
        w_grant = GNT_NONE;
        if (!rstn) begin
            w_grant = GNT_NONE;
        end else if (disp_req) begin
            w_grant = GNT_DISP;
        end else if (w0_valid && w1_valid) begin
            w_grant = r_rr_ptr ? GNT_W1 : GNT_W0;
        end else if (w0_valid) begin
            w_grant = GNT_W0;
        end else if (w1_valid) begin
            w_grant = GNT_W1;
        end
    end

    assign w0_ready = (w_grant == GNT_W0);
    assign w1_ready = (w_grant == GNT_W1);

    always_comb begin
        w_sel_row  = disp_row;
        w_sel_col  = disp_col;
        w_sel_data = '0;
        case (w_grant)
            GNT_W0: begin
                w_sel_row  = w0_row;
                w_sel_col  = w0_col;
                w_sel_data = w0_data;
            end
            GNT_W1: begin
                w_sel_row  = w1_row;
                w_sel_col  = w1_col;
                w_sel_data = w1_data;
            end
            default: begin
                w_sel_row  = disp_row;
                w_sel_col  = disp_col;
                w_sel_data = '0;
            end
        endcase
    end

    vram_addr_calc u_addr_calc (
        .row  (w_sel_row),
        .col  (w_sel_col),
        .addr (w_sel_addr)
    );

    assign w_is_write = (w_grant == GNT_W0) || (w_grant == GNT_W1);

`ifdef VRAM_WR_CLIP_EN
    localparam logic [ROW_W-1:0] c_row_lim = ROW_W'(V_ACTIVE);
    localparam logic [COL_W-1:0] c_col_lim = COL_W'(H_ACTIVE);

    logic [15:0] r_clip_cnt;

    assign w_clip = w_is_write && ((w_sel_row >= c_row_lim) || (w_sel_col >= c_col_lim));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_clip_cnt <= '0;
        end else if (w_clip && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
        end
    end

    assign clip_cnt = r_clip_cnt;
`else
    assign w_clip = 1'b0;
`endif

    assign w_issue = (w_grant != GNT_NONE) && !w_clip;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr     <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_rd_s1      <= 1'b0;
            r_rd_s2      <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
        end else begin
            if (w_grant == GNT_W0) begin
                r_rr_ptr <= 1'b1;
            end else if (w_grant == GNT_W1) begin
                r_rr_ptr <= 1'b0;
            end

            r_mem_en <= w_issue;
            r_mem_we <= w_issue && w_is_write;
            if (w_issue) begin
                r_mem_addr <= w_sel_addr;
                r_mem_din  <= w_sel_data;
            end

            // Read tag follows the access: port at t+1, data at t+2, out at t+3
            r_rd_s1      <= (w_grant == GNT_DISP);
            r_rd_s2      <= r_rd_s1;
            r_disp_valid <= r_rd_s2;
            if (r_rd_s2) begin
                r_disp_data <= mem_dout;
            end
        end
    end

    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    assign disp_valid = r_disp_valid;
    assign disp_data  = r_disp_data;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_arbiter
//  Description : Self-checking bench for vram_arbiter with a behavioural
//                VRAM and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vram_arbiter;
    import vram_pkg::*;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              disp_req;
    logic [8:0]        disp_row;
    logic [9:0]        disp_col;
    logic [11:0]       disp_data;
    logic              disp_valid;
    logic              w0_valid, w0_ready;
    logic [8:0]        w0_row;
    logic [9:0]        w0_col;
    logic [11:0]       w0_data;
    logic              w1_valid, w1_ready;
    logic [8:0]        w1_row;
    logic [9:0]        w1_col;
    logic [11:0]       w1_data;
    logic              mem_en, mem_we;
    logic [18:0]       mem_addr;
    logic [11:0]       mem_din;
    logic [11:0]       mem_dout = '0;
`ifdef VRAM_WR_CLIP_EN
    logic [15:0]       clip_cnt;
`endif

    int checks = 0;
    int errors = 0;

    vram_arbiter dut (
        .clk        (clk),
        .rstn       (rstn),
        .disp_req   (disp_req),
        .disp_row   (disp_row),
        .disp_col   (disp_col),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .w0_valid   (w0_valid),
        .w0_ready   (w0_ready),
        .w0_row     (w0_row),
        .w0_col     (w0_col),
        .w0_data    (w0_data),
        .w1_valid   (w1_valid),
        .w1_ready   (w1_ready),
        .w1_row     (w1_row),
        .w1_col     (w1_col),
        .w1_data    (w1_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
`ifdef VRAM_WR_CLIP_EN
        ,
        .clip_cnt   (clip_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous VRAM
    logic [11:0] vram [0:524287];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] = mem_din;
            else        mem_dout <= vram[mem_addr];
        end
    end

    function automatic logic [11:0] pat(input int a);
        if (a == 0) return 12'hABC;
        return 12'(a * 37 + 5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: expected memory contents and pending display reads
    logic [11:0] shadow [int];
    typedef struct { int due; logic [11:0] d; } rd_t;
    rd_t rdq[$];

    function automatic logic [11:0] model_rd(input int a);
        if (shadow.exists(a)) return shadow[a];
        return pat(a);
    endfunction

    typedef struct {
        logic dr, v0, v1;
        logic r0, r1;
        logic en, we;
    } vec_t;
    vec_t vt [13];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int np;
        int cyc;
        bit last_w1;
        bit pe_en, pe_we;
        int pe_addr;
        logic [11:0] pe_din;
        int exp_clip;
        bit wv [2];
        bit wacc [2];
        int wrow [2];
        int wcol [2];
        logic [11:0] wdat [2];

        disp_req = 0; disp_row = 0; disp_col = 0;
        w0_valid = 0; w0_row = 0; w0_col = 0; w0_data = 0;
        w1_valid = 0; w1_row = 0; w1_col = 0; w1_data = 0;
        for (int i = 0; i < 524288; i++) vram[i] = pat(i);

        //            dr v0 v1 r0 r1 en we   (en/we seen on the port next cycle)
        vt[0]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0, 1'b0,1'b0};
        vt[1]  = '{1'b1,1'b1,1'b1, 1'b0,1'b0, 1'b1,1'b0};
        vt[2]  = '{1'b0,1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b1};
        vt[3]  = '{1'b0,1'b1,1'b1, 1'b0,1'b1, 1'b1,1'b1};
        vt[4]  = '{1'b0,1'b0,1'b1, 1'b0,1'b1, 1'b1,1'b1};
        vt[5]  = '{1'b0,1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b1};
        vt[6]  = '{1'b0,1'b1,1'b0, 1'b1,1'b0, 1'b1,1'b1};
        vt[7]  = '{1'b0,1'b1,1'b1, 1'b0,1'b1, 1'b1,1'b1};
        vt[8]  = '{1'b1,1'b0,1'b1, 1'b0,1'b0, 1'b1,1'b0};
        vt[9]  = '{1'b0,1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b1};
        vt[10] = '{1'b0,1'b0,1'b0, 1'b0,1'b0, 1'b0,1'b0};
        vt[11] = '{1'b0,1'b0,1'b1, 1'b0,1'b1, 1'b1,1'b1};
        vt[12] = '{1'b0,1'b1,1'b1, 1'b1,1'b0, 1'b1,1'b1};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_disp_data", disp_data, 0);
        check("rst_w0_ready", w0_ready, 0);
        check("rst_w1_ready", w1_ready, 0);
`ifdef VRAM_WR_CLIP_EN
        check("rst_clip_cnt", clip_cnt, 0);
`endif
        rstn = 1;
        @(negedge clk);

        // ---------------- arbitration table ----------------
        w0_row = 5; w0_col = 5; w0_data = 12'h555;
        w1_row = 6; w1_col = 6; w1_data = 12'h666;
        for (int i = 0; i < 13; i++) begin
            disp_req = vt[i].dr; w0_valid = vt[i].v0; w1_valid = vt[i].v1;
            #1;
            check($sformatf("tbl%0d_w0_ready", i), w0_ready, vt[i].r0);
            check($sformatf("tbl%0d_w1_ready", i), w1_ready, vt[i].r1);
            if (i > 0) begin
                check($sformatf("tbl%0d_mem_en", i), mem_en, vt[i-1].en);
                check($sformatf("tbl%0d_mem_we", i), mem_we, vt[i-1].we);
            end
            @(negedge clk);
        end
        disp_req = 0; w0_valid = 0; w1_valid = 0;
        #1;
        check("tbl_last_mem_en", mem_en, vt[12].en);
        check("tbl_last_mem_we", mem_we, vt[12].we);
        repeat (5) @(negedge clk);

        // ---------------- read of (0,0) ----------------
        disp_req = 1; disp_row = 0; disp_col = 0;
        @(negedge clk);
        disp_req = 0;
        #1;
        check("rd0_mem_en", mem_en, 1);
        check("rd0_mem_we", mem_we, 0);
        check("rd0_mem_addr", mem_addr, 0);
        @(negedge clk); #1;
        check("rd0_valid_t2", disp_valid, 0);
        @(negedge clk); #1;
        check("rd0_valid_t3", disp_valid, 1);
        check("rd0_data", disp_data, 12'hABC);
        @(negedge clk); #1;
        check("rd0_valid_t4", disp_valid, 0);

        // ---------------- single write ----------------
        @(negedge clk);
        w0_valid = 1; w0_row = 1; w0_col = 2; w0_data = 12'h0F0;
        #1;
        check("wr_w0_ready", w0_ready, 1);
        @(negedge clk);
        w0_valid = 0;
        #1;
        check("wr_mem_en", mem_en, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 642);
        check("wr_mem_din", mem_din, 12'h0F0);

        // ---------------- round-robin contention ----------------
        @(negedge clk);
        w1_valid = 1; w1_row = 1; w1_col = 3; w1_data = 12'h0AA;
        #1;
        check("rr_pre_w1_ready", w1_ready, 1);
        @(negedge clk);
        w0_row = 1; w0_col = 4; w0_data = 12'h111;
        w1_row = 1; w1_col = 5; w1_data = 12'h222;
        for (int k = 0; k < 4; k++) begin
            w0_valid = 1; w1_valid = 1;
            #1;
            check($sformatf("rr%0d_w0_ready", k), w0_ready, (k % 2 == 0));
            check($sformatf("rr%0d_w1_ready", k), w1_ready, (k % 2 == 1));
            check($sformatf("rr%0d_mem_din", k), mem_din,
                  (k == 0) ? 12'h0AA : (((k - 1) % 2 == 0) ? 12'h111 : 12'h222));
            @(negedge clk);
        end
        w0_valid = 0; w1_valid = 0;
        #1;
        check("rr_last_mem_din", mem_din, 12'h222);

        // ---------------- display starvation ----------------
        @(negedge clk);
        np = 0;
        for (int c = 0; c < 11; c++) begin
            disp_req = (c < 5); disp_row = 2; disp_col = 10'(c);
            w1_valid = (c <= 5); w1_row = 1; w1_col = 6; w1_data = 12'h333;
            #1;
            if (c < 5)       check($sformatf("starve%0d_w1_ready", c), w1_ready, 0);
            else if (c == 5) check("starve_w1_granted", w1_ready, 1);
            check($sformatf("starve%0d_disp_valid", c), disp_valid, (c >= 3 && c <= 7));
            if (disp_valid) begin
                check($sformatf("starve_data%0d", np), disp_data, pat(1280 + np));
                np++;
            end
            @(negedge clk);
        end
        check("starve_pulses", np, 5);

        // ---------------- write then read same pixel ----------------
        w0_valid = 1; w0_row = 479; w0_col = 639; w0_data = 12'h123;
        #1;
        check("wr_rd_w0_ready", w0_ready, 1);
        @(negedge clk);
        w0_valid = 0; disp_req = 1; disp_row = 479; disp_col = 639;
        #1;
        check("wr_rd_wr_addr", mem_addr, 307199);
        check("wr_rd_wr_we", mem_we, 1);
        @(negedge clk);
        disp_req = 0;
        #1;
        check("wr_rd_rd_en", mem_en, 1);
        check("wr_rd_rd_we", mem_we, 0);
        check("wr_rd_rd_addr", mem_addr, 307199);
        repeat (2) @(negedge clk);
        #1;
        check("wr_rd_valid", disp_valid, 1);
        check("wr_rd_data", disp_data, 12'h123);
        @(negedge clk);

`ifdef VRAM_WR_CLIP_EN
        // ---------------- clipped write ----------------
        w0_valid = 1; w0_row = 480; w0_col = 0; w0_data = 12'hFFF;
        #1;
        check("clip_w0_ready", w0_ready, 1);
        check("clip_cnt_before", clip_cnt, 0);
        @(negedge clk);
        w0_valid = 0;
        #1;
        check("clip_mem_en", mem_en, 0);
        check("clip_cnt_after", clip_cnt, 1);
        @(negedge clk);
`endif

        // ---------------- reset with a read in flight ----------------
        disp_req = 1; disp_row = 0; disp_col = 0;
        @(negedge clk);
        disp_req = 0;
        #1;
        check("inflight_mem_en", mem_en, 1);
        rstn = 0;
        #1;
        check("async_mem_en_drop", mem_en, 0);
`ifdef VRAM_WR_CLIP_EN
        check("async_clip_cnt", clip_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rstn = 1;
        np = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (disp_valid) np++;
            @(negedge clk);
        end
        check("flush_no_valid", np, 0);

        // ---------------- randomized run against the reference model ----------------
        cyc = 0; last_w1 = 1; pe_en = 0; pe_we = 0; pe_addr = 0; pe_din = 0; exp_clip = 0;
        for (int k = 0; k < 2; k++) begin
            wv[k] = 0; wacc[k] = 0; wrow[k] = 0; wcol[k] = 0; wdat[k] = 0;
        end
        for (int i = 0; i < 3006; i++) begin
            bit g_disp, g0, g1, wr, clipped;
            int a;
            for (int k = 0; k < 2; k++) begin
                if (!wv[k] || wacc[k]) begin
                    wv[k]   = (i < 3000) && ($urandom % 2 == 0);
                    wrow[k] = ($urandom % 8 == 0) ? 480 + int'($urandom % 32) : 10 + int'($urandom % 469);
                    wcol[k] = ($urandom % 8 == 0) ? 640 + int'($urandom % 384) : int'($urandom % 640);
                    wdat[k] = 12'($urandom);
                end
            end
            disp_req = (i < 3000) && ($urandom % 3 == 0);
            disp_row = ($urandom % 8 == 0) ? 9'(480 + $urandom % 32) : 9'(10 + $urandom % 469);
            disp_col = 10'($urandom % 640);
            w0_valid = wv[0]; w0_row = 9'(wrow[0]); w0_col = 10'(wcol[0]); w0_data = wdat[0];
            w1_valid = wv[1]; w1_row = 9'(wrow[1]); w1_col = 10'(wcol[1]); w1_data = wdat[1];
            #1;

            g_disp = disp_req;
            g0 = 0; g1 = 0;
            if (!g_disp) begin
                if (wv[0] && wv[1]) begin
                    g0 = last_w1; g1 = !last_w1;
                end else begin
                    g0 = wv[0]; g1 = wv[1];
                end
            end
            check("rnd_w0_ready", w0_ready, g0);
            check("rnd_w1_ready", w1_ready, g1);
            check("rnd_mem_en", mem_en, pe_en);
            if (pe_en) begin
                check("rnd_mem_we", mem_we, pe_we);
                check("rnd_mem_addr", mem_addr, pe_addr);
                if (pe_we) check("rnd_mem_din", mem_din, pe_din);
            end
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                check("rnd_disp_valid", disp_valid, 1);
                check("rnd_disp_data", disp_data, rdq[0].d);
                void'(rdq.pop_front());
            end else begin
                check("rnd_disp_idle", disp_valid, 0);
            end
`ifdef VRAM_WR_CLIP_EN
            check("rnd_clip_cnt", clip_cnt, exp_clip);
`endif

            wacc[0] = g0; wacc[1] = g1;
            if (g0) last_w1 = 0;
            if (g1) last_w1 = 1;
            wr = g0 || g1;
            if (g_disp)  a = int'(disp_row) * 640 + int'(disp_col);
            else if (g0) a = wrow[0] * 640 + wcol[0];
            else         a = wrow[1] * 640 + wcol[1];
            clipped = 0;
`ifdef VRAM_WR_CLIP_EN
            clipped = wr && ((g0 ? wrow[0] : wrow[1]) >= 480 || (g0 ? wcol[0] : wcol[1]) >= 640);
            if (clipped && exp_clip < 65535) exp_clip++;
`endif
            pe_en = (g_disp || wr) && !clipped;
            pe_we = wr;
            pe_addr = a;
            pe_din = g0 ? wdat[0] : wdat[1];
            if (wr && !clipped) shadow[a] = pe_din;
            if (g_disp) rdq.push_back('{cyc + 3, model_rd(a)});

            @(negedge clk);
            cyc++;
        end
        check("rnd_drain", rdq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
